spy_chain_sweep_ctrl: RTL and testbench

- Measurement sequencer for a chained delay path such as an N-stage inverter chain: drives the chain's `pathInput` and samples its `pathResult`.
- For each wait value from 0 to `maxWait`, it launches `numTrials` transitions into the chain and samples the result exactly `w+1` clock edges after each launch.
- It counts samples that do not yet show the expected level and reports one (wait, fails) record per wait value over a valid/ack handshake.
- Sits between the chain instance and the readout/UART logic; it gives a cycle-resolution settle-latency profile of the path.

---
 rtl/spy_chain_sweep_ctrl_if.sv | 26 ++
 rtl/spy_chain_sweep_ctrl.sv | 129 ++++++++++++
 tb/tb_spy_chain_sweep_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spy_chain_sweep_ctrl_if.sv
// Control/result handshake bundle for the delay-chain sweep sequencer.
// The master side requests sweeps and consumes records; the slave side is the sequencer.
interface spy_chain_sweep_ctrl_if #(
    parameter int WAIT_W  = 8,
    parameter int TRIAL_W = 10
);
    logic               start;
    logic [WAIT_W-1:0]  maxWait;
    logic [TRIAL_W-1:0] numTrials;
    logic               busy;
    logic               resultValid;
    logic [WAIT_W-1:0]  resultWait;
    logic [TRIAL_W-1:0] resultFails;
    logic               resultAck;
    logic               done;

    modport master (
        output start, maxWait, numTrials, resultAck,
        input  busy, resultValid, resultWait, resultFails, done
    );

    modport slave (
        input  start, maxWait, numTrials, resultAck,
        output busy, resultValid, resultWait, resultFails, done
    );
endinterface

// File: rtl/spy_chain_sweep_ctrl.sv
// Settle-latency sweep sequencer: launches toggles into a delay chain and samples the
// chain output a programmable number of cycles later, reporting mismatches per wait value.
module spy_chain_sweep_ctrl #(
    parameter int WAIT_W        = 8,
    parameter int TRIAL_W       = 10,
    parameter int SETTLE_CYC    = 16,
    parameter bit CHAIN_INVERTS = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    spy_chain_sweep_ctrl_if.slave bus,
    output logic                  pathInput,
    input  logic                  pathResult
);
    localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
    localparam int CNT_W    = (WAIT_W > SETTLE_W) ? WAIT_W : SETTLE_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_SAMPLE, S_SETTLE, S_REPORT, S_FINISH
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [WAIT_W-1:0]  r_maxWait;
    logic [TRIAL_W-1:0] r_numTrials;
    logic [WAIT_W-1:0]  r_waitVal;
    logic [TRIAL_W-1:0] r_trial;
    logic [TRIAL_W-1:0] r_fails;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pathInput;
    logic               r_launched;

    logic w_cntLast;
    logic w_moreTrials;
    logic w_lastWait;
    logic w_mismatch;

    assign w_cntLast    = (r_cnt == CNT_W'(1));
    assign w_moreTrials = ((r_trial + TRIAL_W'(1)) < r_numTrials);
    assign w_lastWait   = (r_waitVal == r_maxWait);
    assign w_mismatch   = (pathResult != (r_launched ^ CHAIN_INVERTS));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_nextState = (bus.numTrials != '0) ? S_LAUNCH : S_REPORT;
            end
            S_LAUNCH: w_nextState = (r_waitVal == '0) ? S_SAMPLE : S_WAIT;
            S_WAIT:   if (w_cntLast) w_nextState = S_SAMPLE;
            S_SAMPLE: w_nextState = S_SETTLE;
            S_SETTLE: begin
                if (w_cntLast) w_nextState = w_moreTrials ? S_LAUNCH : S_REPORT;
            end
            // With zero trials per wait value there is nothing to launch, so records stream back-to-back.
            S_REPORT: begin
                if (bus.resultAck) begin
                    if (w_lastWait)              w_nextState = S_FINISH;
                    else if (r_numTrials == '0)  w_nextState = S_REPORT;
                    else                         w_nextState = S_LAUNCH;
                end
            end
            S_FINISH: w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    // r_cnt is shared: loaded with w on launch for the wait phase, then with the settle length.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_maxWait   <= '0;
            r_numTrials <= '0;
            r_waitVal   <= '0;
            r_trial     <= '0;
            r_fails     <= '0;
            r_cnt       <= '0;
            r_pathInput <= 1'b0;
            r_launched  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_maxWait   <= bus.maxWait;
                        r_numTrials <= bus.numTrials;
                        r_waitVal   <= '0;
                        r_trial     <= '0;
                        r_fails     <= '0;
                    end
                end
                S_LAUNCH: begin
                    r_pathInput <= ~r_pathInput;
                    r_launched  <= ~r_pathInput;
                    r_cnt       <= CNT_W'(r_waitVal);
                end
                S_WAIT: r_cnt <= r_cnt - CNT_W'(1);
                S_SAMPLE: begin
                    if (w_mismatch) r_fails <= r_fails + TRIAL_W'(1);
                    r_cnt <= CNT_W'(SETTLE_CYC);
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_cntLast && w_moreTrials) r_trial <= r_trial + TRIAL_W'(1);
                end
                S_REPORT: begin
                    if (bus.resultAck && !w_lastWait) begin
                        r_waitVal <= r_waitVal + WAIT_W'(1);
                        r_trial   <= '0;
                        r_fails   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy        = (r_state != S_IDLE);
        bus.resultValid = (r_state == S_REPORT);
        bus.done        = (r_state == S_FINISH);
        bus.resultWait  = r_waitVal;
        bus.resultFails = r_fails;
        pathInput       = r_pathInput;
    end
endmodule

// File: tb/tb_spy_chain_sweep_ctrl.sv
// Bench for the sweep sequencer: two instances (straight and inverted parity) each drive a
// 3-flop chain model; records are checked against a scoreboard of expected (wait, fails).
module tb_spy_chain_sweep_ctrl;
    localparam int WAIT_W      = 8;
    localparam int TRIAL_W     = 10;
    localparam int SETTLE_CYC  = 16;
    localparam int CHAIN_DEPTH = 3;

    typedef struct {
        int waitVal;
        int fails;
    } rec_t;

    typedef struct {
        int sel;
        int maxW;
        int nTr;
        int expRecords;
        int expToggles;
    } sweepVec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pathIn0, pathIn1;
    logic [CHAIN_DEPTH-1:0] chain0 = '0;
    logic [CHAIN_DEPTH-1:0] chain1 = '0;

    int   nChecks = 0;
    int   nFails  = 0;
    rec_t expQ[$];
    int   records[2];
    int   toggles[2];
    int   doneCount[2];
    int   doneBase[2];
    logic prevDone[2];
    logic prevPath[2];

    spy_chain_sweep_ctrl_if #(.WAIT_W(WAIT_W), .TRIAL_W(TRIAL_W)) bus0 ();
    spy_chain_sweep_ctrl_if #(.WAIT_W(WAIT_W), .TRIAL_W(TRIAL_W)) bus1 ();

    spy_chain_sweep_ctrl #(
        .WAIT_W(WAIT_W), .TRIAL_W(TRIAL_W), .SETTLE_CYC(SETTLE_CYC), .CHAIN_INVERTS(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .pathInput(pathIn0), .pathResult(chain0[CHAIN_DEPTH-1])
    );

    spy_chain_sweep_ctrl #(
        .WAIT_W(WAIT_W), .TRIAL_W(TRIAL_W), .SETTLE_CYC(SETTLE_CYC), .CHAIN_INVERTS(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .pathInput(pathIn1), .pathResult(chain1[CHAIN_DEPTH-1])
    );

    always #5 clk = ~clk;

    // Non-inverting chain model: the launched level reaches the output CHAIN_DEPTH edges later.
    always @(posedge clk) begin
        chain0 <= {chain0[CHAIN_DEPTH-2:0], pathIn0};
        chain1 <= {chain1[CHAIN_DEPTH-2:0], pathIn1};
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Sample reaches the settled level only when w+1 > CHAIN_DEPTH; inverted parity flips the verdict.
    function automatic int expFails(input int sel, input int w, input int n);
        bit settled;
        settled = (w >= CHAIN_DEPTH);
        return ((settled ^ (sel == 1)) != 0) ? 0 : n;
    endfunction

    function automatic logic busyOf(input int sel);
        return (sel == 0) ? bus0.busy : bus1.busy;
    endfunction

    task automatic setInputs(input int sel, input logic st, input int m, input int n);
        if (sel == 0) begin
            bus0.start = st; bus0.maxWait = WAIT_W'(m); bus0.numTrials = TRIAL_W'(n);
        end else begin
            bus1.start = st; bus1.maxWait = WAIT_W'(m); bus1.numTrials = TRIAL_W'(n);
        end
    endtask

    task automatic monitorBus(input int sel, input logic valid, input logic ack, input int waitV,
                              input int failsV, input logic done, input logic busy, input logic pathV);
        rec_t e;
        if (rst) begin
            prevDone[sel] = 1'b0;
            prevPath[sel] = pathV;
        end else begin
            if (pathV !== prevPath[sel]) toggles[sel]++;
            prevPath[sel] = pathV;
            if (prevDone[sel]) checkOutput("busyAfterDone", int'(busy), 0);
            if (done) begin
                doneCount[sel]++;
                checkOutput("busyDuringDone", int'(busy), 1);
            end
            prevDone[sel] = done;
            if (valid && ack) begin
                records[sel]++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedRecordWait", waitV, -1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("recWait", waitV, e.waitVal);
                    checkOutput("recFails", failsV, e.fails);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        monitorBus(0, bus0.resultValid, bus0.resultAck, int'(bus0.resultWait),
                   int'(bus0.resultFails), bus0.done, bus0.busy, pathIn0);
        monitorBus(1, bus1.resultValid, bus1.resultAck, int'(bus1.resultWait),
                   int'(bus1.resultFails), bus1.done, bus1.busy, pathIn1);
    end

    task automatic checkResetState();
        checkOutput("rstPathInput", int'(pathIn0), 0);
        checkOutput("rstBusy", int'(bus0.busy), 0);
        checkOutput("rstValid", int'(bus0.resultValid), 0);
        checkOutput("rstDone", int'(bus0.done), 0);
        checkOutput("rstWait", int'(bus0.resultWait), 0);
        checkOutput("rstFails", int'(bus0.resultFails), 0);
    endtask

    // Pushes the expected records, pulses start, then scrambles the inputs to prove they were latched.
    task automatic startSweep(input int sel, input int m, input int n);
        for (int w = 0; w <= m; w++) expQ.push_back('{w, expFails(sel, w, n)});
        doneBase[sel] = doneCount[sel];
        @(posedge clk); #1;
        setInputs(sel, 1'b1, m, n);
        @(posedge clk); #1;
        setInputs(sel, 1'b0, m + 3, n + 5);
    endtask

    task automatic waitDone(input int sel, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (doneCount[sel] != doneBase[sel]) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("doneWithinBudget", int'(seen), 1);
    endtask

    task automatic applyStimulus(input sweepVec_t v);
        records[v.sel] = 0;
        toggles[v.sel] = 0;
        startSweep(v.sel, v.maxW, v.nTr);
        waitDone(v.sel, 4000);
        repeat (4) @(negedge clk);
        checkOutput("recordCount", records[v.sel], v.expRecords);
        checkOutput("pathToggles", toggles[v.sel], v.expToggles);
        checkOutput("donePulses", doneCount[v.sel] - doneBase[v.sel], 1);
        checkOutput("leftoverRecords", expQ.size(), 0);
        checkOutput("busyIdle", int'(busyOf(v.sel)), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        sweepVec_t vecs[5];
        bit found;
        for (int s = 0; s < 2; s++) begin
            records[s] = 0; toggles[s] = 0; doneCount[s] = 0; doneBase[s] = 0;
            prevDone[s] = 1'b0; prevPath[s] = 1'b0;
        end
        vecs[0] = '{0, 5, 4, 6, 24};
        vecs[1] = '{1, 5, 4, 6, 24};
        vecs[2] = '{0, 2, 0, 3, 0};
        vecs[3] = '{0, 0, 3, 1, 3};
        vecs[4] = '{0, 3, 1, 4, 4};

        setInputs(0, 1'b0, 0, 0);
        setInputs(1, 1'b0, 0, 0);
        bus0.resultAck = 1'b1;
        bus1.resultAck = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetState();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);

        $display("[TB] table-driven sweeps");
        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        $display("[TB] backpressure on first record");
        records[0] = 0;
        toggles[0] = 0;
        #1 bus0.resultAck = 1'b0;
        startSweep(0, 1, 2);
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus0.resultValid) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("bpValidSeen", int'(found), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bpValidHeld", int'(bus0.resultValid), 1);
            checkOutput("bpWaitHeld", int'(bus0.resultWait), 0);
            checkOutput("bpFailsHeld", int'(bus0.resultFails), 2);
            checkOutput("bpNoLaunch", toggles[0], 2);
        end
        @(posedge clk); #1;
        bus0.resultAck = 1'b1;
        waitDone(0, 2000);
        repeat (4) @(negedge clk);
        checkOutput("bpRecordCount", records[0], 2);
        checkOutput("bpLeftover", expQ.size(), 0);

        $display("[TB] reset during wait phase of w=2");
        startSweep(0, 5, 4);
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus0.resultValid && bus0.resultAck && (bus0.resultWait == WAIT_W'(1))) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("midResetReachedW1", int'(found), 1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkResetState();
        expQ.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        applyStimulus('{0, 5, 4, 6, 24});

        $display("[TB] start while busy is ignored");
        records[0] = 0;
        startSweep(0, 2, 1);
        repeat (20) @(posedge clk);
        #1 setInputs(0, 1'b1, 7, 3);
        @(posedge clk); #1;
        setInputs(0, 1'b0, 0, 0);
        waitDone(0, 3000);
        repeat (30) @(negedge clk);
        checkOutput("busyStartRecords", records[0], 3);
        checkOutput("busyStartLeftover", expQ.size(), 0);
        checkOutput("busyStartDonePulses", doneCount[0] - doneBase[0], 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
